// File: rtl/divider.sv
// divider: sequential 32-bit DIV/DIVU unit for the EX stage, radix-2 restoring, one quotient bit per cycle.
// Latency: done pulses 33 cycles after the start-sampling edge, or 1 cycle after it for a zero divisor.
// Backpressure: start is accepted only in IDLE; busy (CALC/DONE) stalls EX; cancel aborts on the next edge.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, signed_flag    operation request and DIV(1)/DIVU(0) select, sampled together in IDLE
//   dividend, divisor     32-bit operands, sampled with start
//   cancel                pipeline flush, forces IDLE and suppresses the pending result
//   busy, done            busy in CALC/DONE; done is a one-cycle result-valid pulse
//   result                {remainder, quotient}, held until the next DONE or reset
module divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_flag,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [63:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q,  state_d;
    logic [5:0]  cnt_q,    cnt_d;
    logic [31:0] rem_q,    rem_d;     // partial remainder
    logic [31:0] quo_q,    quo_d;     // dividend shifts out MSB-first, quotient bits shift in
    logic [31:0] dvsr_q,   dvsr_d;    // divisor magnitude
    logic        q_neg_q,  q_neg_d;
    logic        r_neg_q,  r_neg_d;
    logic [63:0] result_q, result_d;

    // One restoring step. The remainder is always below the divisor, so the
    // shifted partial fits in 33 bits and bit 32 of the difference is the borrow.
    logic [32:0] partial;
    logic [32:0] diff;
    logic        q_bit;
    logic [31:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] q_final;
    logic [31:0] r_final;

    // Operand magnitudes for acceptance in IDLE
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    always_comb begin
        partial  = {rem_q, quo_q[31]};
        diff     = partial - {1'b0, dvsr_q};
        q_bit    = ~diff[32];
        rem_step = q_bit ? diff[31:0] : partial[31:0];
        quo_step = {quo_q[30:0], q_bit};
        // Sign fix-up is applied to the final-step values so the registered
        // result is already in two's-complement form when DONE is entered.
        q_final  = q_neg_q ? (~quo_step + 32'd1) : quo_step;
        r_final  = r_neg_q ? (~rem_step + 32'd1) : rem_step;

        a_neg    = signed_flag & dividend[31];
        b_neg    = signed_flag & divisor[31];
        a_mag    = a_neg ? (~dividend + 32'd1) : dividend;
        b_mag    = b_neg ? (~divisor  + 32'd1) : divisor;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    cnt_d   = 6'd0;
                    rem_d   = 32'd0;
                    quo_d   = a_mag;
                    dvsr_d  = b_mag;
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                    if (divisor == 32'd0) begin
                        // Divide by zero: all-ones quotient, original dividend as remainder
                        state_d  = S_DONE;
                        result_d = {dividend, 32'hFFFF_FFFF};
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d  = S_DONE;
                    result_d = {r_final, q_final};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush wins over everything, including a final-iteration result load
        if (cancel) begin
            state_d  = S_IDLE;
            cnt_d    = 6'd0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            dvsr_q   <= 32'd0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= 64'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_CALC) || (state_q == S_DONE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_divider.sv
module tb_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_flag;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int          nvec = 0;
    int          nerr = 0;
    logic [63:0] last_exp;

    divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_flag (signed_flag),
        .dividend    (dividend),
        .divisor     (divisor),
        .cancel      (cancel),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got incomplete run want finished run");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer division on 64-bit values, low 32 bits kept
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input string name);
        logic [63:0] exp;
        int cyc, exp_lat, busy_cnt;
        exp      = model(a, b, s);
        exp_lat  = (b == 32'd0) ? 1 : 33;
        dividend = a;
        divisor  = b;
        signed_flag = s;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_cnt++;
            tick();
            cyc++;
        end
        if (busy) busy_cnt++;
        nvec++;
        if (done !== 1'b1 || cyc != exp_lat) begin
            nerr++;
            $display("FAIL %s latency: got done=%b at cycle %0d, want cycle %0d", name, done, cyc, exp_lat);
        end
        nvec++;
        if (result !== exp) begin
            nerr++;
            $display("FAIL %s result: got %h want %h", name, result, exp);
        end
        nvec++;
        if (busy_cnt != exp_lat) begin
            nerr++;
            $display("FAIL %s busy cycles: got %0d want %0d", name, busy_cnt, exp_lat);
        end
        tick();
        nvec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL %s after done: got done=%b busy=%b want 0 0", name, done, busy);
        end
        last_exp = exp;
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; cancel = 1'b0; signed_flag = 1'b0;
        dividend = 32'd0; divisor = 32'd0;
        #2 rst = 1'b1;
        #1;
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd0) begin
            nerr++;
            $display("FAIL reset: got busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd0) begin
            nerr++;
            $display("FAIL reset release: got busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        last_exp = 64'd0;
    endtask

    task automatic test_directed;
        run_op(32'd100,        32'd7,          1'b0, "udiv_100_7");
        run_op(32'hFFFF_FFF9,  32'd2,          1'b1, "sdiv_m7_2");
        run_op(32'hFFFF_FFF9,  32'd2,          1'b0, "udiv_fff9_2");
        run_op(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, "sdiv_overflow");
        run_op(32'd5,          32'd0,          1'b0, "udiv_by_zero");
        run_op(32'hFFFF_FF00,  32'd0,          1'b1, "sdiv_by_zero");
        run_op(32'd7,          32'hFFFF_FFFE,  1'b1, "sdiv_7_m2");
        run_op(32'hFFFF_FFFF,  32'd1,          1'b0, "udiv_max_1");
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic s;
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: b = b | 32'h8000_0000;
                default: ;
            endcase
            run_op(a, b, s, "random");
        end
    endtask

    task automatic test_cancel;
        int cyc;
        logic bad;
        dividend = 32'd100; divisor = 32'd7; signed_flag = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 10) begin tick(); cyc++; end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            nerr++;
            $display("FAIL cancel: got busy=%b done=%b want 0 0", busy, done);
        end
        bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done !== 1'b0 || result !== last_exp) bad = 1'b1;
            tick();
        end
        nvec++;
        if (bad) begin
            nerr++;
            $display("FAIL cancel aftermath: got done or result change, want result %h held", last_exp);
        end
        run_op(32'd9, 32'd3, 1'b0, "after_cancel_9_3");

        // cancel and start together in IDLE: nothing accepted
        dividend = 32'd50; divisor = 32'd5; start = 1'b1; cancel = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b0;
        nvec++;
        if (busy !== 1'b0) begin
            nerr++;
            $display("FAIL cancel_vs_start: got busy=%b want 0", busy);
        end
        repeat (3) tick();
        nvec++;
        if (busy !== 1'b0 || result !== last_exp) begin
            nerr++;
            $display("FAIL cancel_vs_start hold: got busy=%b result=%h want 0 %h", busy, result, last_exp);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        logic bad;
        dividend = 32'd100; divisor = 32'd7; signed_flag = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 15) begin tick(); cyc++; end
        #1 rst = 1'b1;
        #1;
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd0) begin
            nerr++;
            $display("FAIL reset_mid: got busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        tick();
        rst = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
            tick();
        end
        nvec++;
        if (bad) begin
            nerr++;
            $display("FAIL reset_mid aftermath: got done/busy activity want idle");
        end
        run_op(32'd1, 32'd1, 1'b0, "after_reset_1_1");
    endtask

    task automatic test_back_to_back;
        int n_done, d_cyc[4];
        logic [63:0] d_res[4];
        logic [63:0] exp_a, exp_b;
        exp_a = model(32'd1000, 32'd10, 1'b0);
        exp_b = model(32'd77, 32'd5, 1'b0);
        dividend = 32'd1000; divisor = 32'd10; signed_flag = 1'b0; start = 1'b1;
        tick();
        dividend = 32'd77; divisor = 32'd5;
        n_done = 0;
        for (int cyc = 1; cyc <= 75; cyc++) begin
            if (done && n_done < 4) begin
                d_cyc[n_done] = cyc;
                d_res[n_done] = result;
                n_done++;
            end
            tick();
        end
        start = 1'b0;
        for (int k = 0; k < 40 && busy; k++) tick();
        last_exp = exp_b;
        nvec++;
        if (n_done != 2) begin
            nerr++;
            $display("FAIL b2b count: got %0d done pulses want 2", n_done);
        end else begin
            nvec++;
            if (d_cyc[0] != 33 || d_cyc[1] != 67) begin
                nerr++;
                $display("FAIL b2b timing: got cycles %0d %0d want 33 67", d_cyc[0], d_cyc[1]);
            end
            nvec++;
            if (d_res[0] !== exp_a || d_res[1] !== exp_b) begin
                nerr++;
                $display("FAIL b2b results: got %h %h want %h %h", d_res[0], d_res[1], exp_a, exp_b);
            end
        end
    endtask

    task automatic test_ignored_start;
        int cyc;
        logic [63:0] exp;
        exp = model(32'd12345, 32'd67, 1'b0);
        dividend = 32'd12345; divisor = 32'd67; signed_flag = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin
            if (cyc == 10) begin
                dividend = 32'hFFFF_0000; divisor = 32'd3; signed_flag = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        nvec++;
        if (done !== 1'b1 || cyc != 33 || result !== exp) begin
            nerr++;
            $display("FAIL ignored_start: got done=%b cycle %0d result %h want 1 33 %h", done, cyc, result, exp);
        end
        tick();
        nvec++;
        if (busy !== 1'b0) begin
            nerr++;
            $display("FAIL ignored_start idle: got busy=%b want 0", busy);
        end
        last_exp = exp;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        test_ignored_start();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
